// File: rtl/ariane_soc.sv
// Shared SoC constants: Paper window location, register offsets, AXI response
// encoding and the small types used by the Paper config slave.
package ariane_soc;

  localparam logic [63:0] PaperBase   = 64'h1900_0000;
  localparam logic [63:0] PaperLength = 64'h0000_1000;

  localparam logic [11:0] PaperCtrlOff    = 12'h000;
  localparam logic [11:0] PaperStatusOff  = 12'h004;
  localparam logic [11:0] PaperFbLoOff    = 12'h008;
  localparam logic [11:0] PaperFbHiOff    = 12'h00C;
  localparam logic [11:0] PaperScratchOff = 12'h010;
  localparam logic [11:0] PaperCyclesOff  = 12'h014;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    REG_CTRL, REG_STATUS, REG_FB_LO, REG_FB_HI, REG_SCRATCH, REG_CYCLES, REG_NONE
  } paper_reg_e;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} paper_w_state_e;
  typedef enum logic       {R_IDLE, R_RESP} paper_r_state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/paper_cfg_decode.sv
// Address -> {register, response} decoder for the Paper window; used by both
// the read and the write channel.
module paper_cfg_decode
  import ariane_soc::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter logic [63:0] BaseAddr  = PaperBase
) (
  input  logic [AddrWidth-1:0] i_addr,
  input  logic                 i_write,
  output paper_reg_e           o_reg,
  output axi_resp_e            o_resp
);

  logic [11:0] w_off;

  always_comb begin
    w_off  = i_addr[11:0];
    o_reg  = REG_NONE;
    o_resp = RESP_OKAY;
    if (i_addr[AddrWidth-1:12] != BaseAddr[AddrWidth-1:12]) begin
      o_resp = RESP_DECERR;
    end else begin
      // Anything not an exact register offset (too high or misaligned) is SLVERR.
      case (w_off)
        PaperCtrlOff:    o_reg = REG_CTRL;
        PaperStatusOff:  o_reg = REG_STATUS;
        PaperFbLoOff:    o_reg = REG_FB_LO;
        PaperFbHiOff:    o_reg = REG_FB_HI;
        PaperScratchOff: o_reg = REG_SCRATCH;
        PaperCyclesOff:  o_reg = REG_CYCLES;
        default:         o_resp = RESP_SLVERR;
      endcase
      if (i_write && (o_reg == REG_STATUS || o_reg == REG_CYCLES)) begin
        o_reg  = REG_NONE;
        o_resp = RESP_SLVERR;
      end
    end
  end

endmodule

// File: rtl/paper_cfg_slave.sv
// AXI4-Lite register slave for the Paper window: independent read/write FSMs,
// small register file and control outputs into the Paper datapath.
module paper_cfg_slave
  import ariane_soc::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 32,
  parameter logic [63:0] BaseAddr  = PaperBase
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  output logic [1:0]             b_resp_o,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  input  logic [AddrWidth-1:0]   ar_addr_i,
  input  logic                   ar_valid_i,
  output logic                   ar_ready_o,
  output logic [DataWidth-1:0]   r_data_o,
  output logic [1:0]             r_resp_o,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  input  logic [7:0]             status_i,
  output logic                   enable_o,
  output logic                   irq_en_o,
  output logic [63:0]            fb_base_o
);

  paper_w_state_e r_w_state, w_w_state_d;
  paper_r_state_e r_r_state, w_r_state_d;

  logic                   r_aw_ready, r_w_ready, r_b_valid, r_ar_ready, r_r_valid;
  axi_resp_e              r_b_resp, r_r_resp;
  logic [DataWidth-1:0]   r_r_data;
  logic [AddrWidth-1:0]   r_aw_addr;
  logic [DataWidth-1:0]   r_w_data;
  logic [DataWidth/8-1:0] r_w_strb;

  logic [1:0]           r_ctrl;
  logic [DataWidth-1:0] r_fb_lo, r_fb_hi, r_scratch, r_cycles;

  logic                   w_aw_fire, w_w_fire, w_ar_fire, w_commit;
  logic [AddrWidth-1:0]   w_wr_addr;
  logic [DataWidth-1:0]   w_wr_data, w_rd_data;
  logic [DataWidth/8-1:0] w_wr_strb;
  paper_reg_e             w_wr_reg, w_rd_reg;
  axi_resp_e              w_wr_resp, w_rd_resp;

  assign w_aw_fire = aw_valid_i & r_aw_ready;
  assign w_w_fire  = w_valid_i & r_w_ready;
  assign w_ar_fire = ar_valid_i & r_ar_ready;

  // On the completing handshake the half not yet captured comes straight from the bus.
  assign w_wr_addr = (r_w_state == W_HAVE_AW) ? r_aw_addr : aw_addr_i;
  assign w_wr_data = (r_w_state == W_HAVE_W)  ? r_w_data  : w_data_i;
  assign w_wr_strb = (r_w_state == W_HAVE_W)  ? r_w_strb  : w_strb_i;

  paper_cfg_decode #(.AddrWidth(AddrWidth), .BaseAddr(BaseAddr)) u_wr_dec (
    .i_addr(w_wr_addr), .i_write(1'b1), .o_reg(w_wr_reg), .o_resp(w_wr_resp)
  );

  paper_cfg_decode #(.AddrWidth(AddrWidth), .BaseAddr(BaseAddr)) u_rd_dec (
    .i_addr(ar_addr_i), .i_write(1'b0), .o_reg(w_rd_reg), .o_resp(w_rd_resp)
  );

  always_comb begin
    w_w_state_d = r_w_state;
    w_commit    = 1'b0;
    case (r_w_state)
      W_IDLE: begin
        if (aw_valid_i && w_valid_i) begin
          w_commit    = 1'b1;
          w_w_state_d = W_RESP;
        end else if (aw_valid_i) begin
          w_w_state_d = W_HAVE_AW;
        end else if (w_valid_i) begin
          w_w_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_valid_i) begin
        w_commit    = 1'b1;
        w_w_state_d = W_RESP;
      end
      W_HAVE_W: if (aw_valid_i) begin
        w_commit    = 1'b1;
        w_w_state_d = W_RESP;
      end
      W_RESP: if (b_ready_i) w_w_state_d = W_IDLE;
      default: w_w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    w_r_state_d = r_r_state;
    case (r_r_state)
      R_IDLE:  if (ar_valid_i) w_r_state_d = R_RESP;
      R_RESP:  if (r_ready_i)  w_r_state_d = R_IDLE;
      default: w_r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_rd_data = '0;
    case (w_rd_reg)
      REG_CTRL:    w_rd_data = {30'b0, r_ctrl};
      REG_STATUS:  w_rd_data = {24'b0, status_i};
      REG_FB_LO:   w_rd_data = r_fb_lo;
      REG_FB_HI:   w_rd_data = r_fb_hi;
      REG_SCRATCH: w_rd_data = r_scratch;
      REG_CYCLES:  w_rd_data = r_cycles;
      default:     w_rd_data = '0;
    endcase
  end

  // Handshake flops are loaded from the next state so every ready/valid is a register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_w_state  <= W_IDLE;
      r_r_state  <= R_IDLE;
      r_aw_ready <= 1'b1;
      r_w_ready  <= 1'b1;
      r_ar_ready <= 1'b1;
      r_b_valid  <= 1'b0;
      r_r_valid  <= 1'b0;
      r_b_resp   <= RESP_OKAY;
      r_r_resp   <= RESP_OKAY;
      r_r_data   <= '0;
      r_aw_addr  <= '0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
    end else begin
      r_w_state  <= w_w_state_d;
      r_r_state  <= w_r_state_d;
      r_aw_ready <= (w_w_state_d == W_IDLE) || (w_w_state_d == W_HAVE_W);
      r_w_ready  <= (w_w_state_d == W_IDLE) || (w_w_state_d == W_HAVE_AW);
      r_b_valid  <= (w_w_state_d == W_RESP);
      r_ar_ready <= (w_r_state_d == R_IDLE);
      r_r_valid  <= (w_r_state_d == R_RESP);
      if (w_aw_fire) r_aw_addr <= aw_addr_i;
      if (w_w_fire) begin
        r_w_data <= w_data_i;
        r_w_strb <= w_strb_i;
      end
      if (w_commit) r_b_resp <= w_wr_resp;
      if (w_ar_fire) begin
        r_r_resp <= w_rd_resp;
        r_r_data <= (w_rd_resp == RESP_OKAY) ? w_rd_data : '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ctrl    <= '0;
      r_fb_lo   <= '0;
      r_fb_hi   <= '0;
      r_scratch <= '0;
      r_cycles  <= '0;
    end else begin
      r_cycles <= r_cycles + 1'b1;
      if (w_commit && w_wr_resp == RESP_OKAY) begin
        case (w_wr_reg)
          REG_CTRL:    r_ctrl    <= byte_merge({30'b0, r_ctrl}, w_wr_data, w_wr_strb) & 32'h3;
          REG_FB_LO:   r_fb_lo   <= byte_merge(r_fb_lo,   w_wr_data, w_wr_strb);
          REG_FB_HI:   r_fb_hi   <= byte_merge(r_fb_hi,   w_wr_data, w_wr_strb);
          REG_SCRATCH: r_scratch <= byte_merge(r_scratch, w_wr_data, w_wr_strb);
          default: ;
        endcase
      end
    end
  end

  assign aw_ready_o = r_aw_ready;
  assign w_ready_o  = r_w_ready;
  assign b_valid_o  = r_b_valid;
  assign b_resp_o   = r_b_resp;
  assign ar_ready_o = r_ar_ready;
  assign r_valid_o  = r_r_valid;
  assign r_resp_o   = r_r_resp;
  assign r_data_o   = r_r_data;
  assign enable_o   = r_ctrl[0];
  assign irq_en_o   = r_ctrl[1];
  assign fb_base_o  = {r_fb_hi, r_fb_lo};

endmodule

// File: doc/paper_cfg_slave.md
# paper_cfg_slave

AXI4-Lite responder for the Paper peripheral window (base 0x1900_0000, length 0x1000) of the Ariane SoC crossbar. Accepts the transactions that the crossbar routes to the Paper slave port, decodes the 4 KiB window into a small register file, and drives control outputs into the Paper datapath. Reads and writes are handled by independent channels and may be in flight at the same time.

## Interface
- `AddrWidth`, 64: AXI address width.
- `DataWidth`, 32: AXI data width; fixed at 32, other values are unsupported.
- `BaseAddr`, 64'h1900_0000: window base; must equal the shared-package `PaperBase`.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous reset, active-high.
- `aw_addr_i`  in  AddrWidth  write address; `aw_valid_i` in 1; `aw_ready_o` out 1.
- `w_data_i`  in  32  write data; `w_strb_i` in 4 byte enables; `w_valid_i` in 1; `w_ready_o` out 1.
- `b_resp_o`  out  2  write response; `b_valid_o` out 1; `b_ready_i` in 1.
- `ar_addr_i`  in  AddrWidth  read address; `ar_valid_i` in 1; `ar_ready_o` out 1.
- `r_data_o`  out  32  read data; `r_resp_o` out 2; `r_valid_o` out 1; `r_ready_i` in 1.
- `status_i`  in  8  live status from the Paper datapath.
- `enable_o`  out  1  CTRL[0].
- `irq_en_o`  out  1  CTRL[1].
- `fb_base_o`  out  64  {FB_HI, FB_LO}.

## Operation
- Register map, byte offset = addr[11:0]:
  - 0x00 CTRL: RW, bits [1:0]; other bits read as 0.
  - 0x04 STATUS: RO, {24'b0, status_i}.
  - 0x08 FB_LO: RW.
  - 0x0C FB_HI: RW.
  - 0x10 SCRATCH: RW.
  - 0x14 CYCLES: RO, 32-bit free-running counter that wraps from 0xFFFF_FFFF to 0.
- Address decode, applied to reads and writes:
  - addr[AddrWidth-1:12] != BaseAddr[AddrWidth-1:12] → DECERR (2'b11).
  - Offset > 0x14, or addr[1:0] != 0 → SLVERR (2'b10).
  - Write to a RO register → SLVERR.
  - Every error has no side effect, and error reads return 0.
  - OKAY is 2'b00.
- Writes are byte-masked by `w_strb_i`; a strobe of 0 gives OKAY and no change.
- Write FSM:
  - States: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - AW and W are accepted independently in any order, and each is captured once.
  - `aw_ready_o` = state ∈ {W_IDLE, W_HAVE_W}; `w_ready_o` = state ∈ {W_IDLE, W_HAVE_AW}.
  - When both are captured: commit the write and enter W_RESP.
  - In W_RESP, hold `b_valid_o`=1 with a stable `b_resp_o` until `b_ready_i`, then return to W_IDLE.
- Read FSM:
  - States: R_IDLE, R_RESP.
  - `ar_ready_o` = (state == R_IDLE).
  - On handshake: register data and response, enter R_RESP.
  - Hold `r_valid_o`, `r_data_o` and `r_resp_o` stable until `r_ready_i`, then return to R_IDLE.
  - No read-data bypass: `ar_ready_o` stays 0 in R_RESP even if `r_ready_i` is high.
- Simultaneous commit and read sample of the same register: the read returns the pre-write value.

## Timing
- Reset values:
  - Control outputs: `enable_o`=0, `irq_en_o`=0, `fb_base_o`=0.
  - Registers: SCRATCH=0, CYCLES=0.
  - Handshake outputs: all valids=0, `aw_ready_o`/`w_ready_o`/`ar_ready_o`=1.
  - Data outputs: `b_resp_o`=0, `r_data_o`=0, `r_resp_o`=0.
  - FSMs: W_IDLE, R_IDLE.
- Write latency: the last of the AW/W handshakes at cycle N → register and outputs updated and `b_valid_o`=1 at N+1.
- Read latency: AR handshake at cycle N → `r_valid_o`=1 at N+1, with data sampled at N.
- CYCLES increments every cycle, including cycles with a pending response.
- Reset asserted mid-transaction: all state and response channels clear on the next edge. A pending response is dropped, not completed.
- Outputs are purely registered; there are no combinational paths from inputs to valid or ready outputs.

## Structure
- `PaperBase`, `PaperLength`, the register offset localparams and the AXI response encoding belong in the shared SoC package (`ariane_soc`).
- One sub-module, `paper_cfg_decode`: combinational address → {register index, resp} decoder, shared by both channels.
- The FSMs and the register file live in the top module.

## Test plan
- Reset, then read 0x1900_0000 and 0x1900_0004 with `status_i`=8'hA5 → 32'h0 OKAY, then 32'h0000_00A5 OKAY, each `r_valid_o` one cycle after AR.
- W at cycle 0, AW at cycle 3 to 0x1900_0008, data 0xDEAD_BEEF, strobe 4'b0011 → `b_valid_o` at cycle 4 with OKAY; `fb_base_o`=64'h0000_0000_0000_BEEF.
- Write 0x3 to CTRL with `b_ready_i` held low for 5 cycles → `b_valid_o`/OKAY stable for all 5 cycles, `aw_ready_o`=0 throughout; `enable_o`=1, `irq_en_o`=1.
- Read 0x1900_0018 → SLVERR, data 0. Write to 0x1900_0004 → SLVERR, STATUS unchanged. Read 0x1800_0000 → DECERR.
- Write SCRATCH=0x1234 committing in the same cycle as an AR to SCRATCH (old value 0) → read returns 0; a following read returns 0x1234.
- Read CYCLES twice, 10 cycles apart → difference is 10. Force the counter to 0xFFFF_FFFF → next value is 0.
